run_control_unit: RTL and testbench

- Parametrised run/step controller for the pipelined ARM core, sitting between board clock/step inputs and the core's clock-enable.
- Generalises free-run vs single-step selection to:
  - instruction-limited runs;
  - a cycle-budget watchdog, budget = instructions x (1 + stalls per instruction);
  - cycle, instruction and stall counters for the core.
- Drives `cpu_en` to the core. Reads `retire` and `stall` back from the core.

---
 rtl/run_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_run_control_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_control_unit.sv
// Run/step controller gating the ARM core clock-enable, with instruction-limit stop,
// cycle-budget watchdog and run counters. Optional breakpoint logic under RUN_CTRL_BREAK_EN.
module run_control_unit #(
  parameter int CNT_W            = 32,
  parameter int STALLS_PER_INSTR = 5,
  parameter bit SAT_EN_DEFAULT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_select,
  input  logic             clk_step,
  input  logic             start,
  input  logic [CNT_W-1:0] instr_limit,
  input  logic             retire,
  input  logic             stall,
`ifdef RUN_CTRL_BREAK_EN
  input  logic             break_valid,
  input  logic [31:0]      break_pc,
  input  logic [31:0]      pc,
  output logic             brk_hit,
`endif
  output logic             cpu_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN        = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_PULSE = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam int                 BW     = 2 * CNT_W;
  localparam logic [BW-1:0]      MULT_W = BW'(STALLS_PER_INSTR + 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              clk_step_q_r;
  logic              step_rise_s;
  logic              start_ok_s;
  logic              limit_hit_s;
  logic              wd_hit_s;
  logic              stop_s;
  logic              wd_only_s;
  logic              brk_take_s;
  logic              brk_hold_s;
  logic [BW-1:0]     budget_s;
  logic [BW-1:0]     cyc_next_s;
  logic [CNT_W:0]    instr_next_s;

  // Counter increment that either saturates at all-ones or wraps to zero.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      cnt_inc = SAT_EN_DEFAULT ? v : {CNT_W{1'b0}};
    end else begin
      cnt_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign step_rise_s  = clk_step & ~clk_step_q_r;
  assign start_ok_s   = start & ((state_r == IDLE) || (state_r == DONE));
  assign instr_next_s = {1'b0, instr_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign cyc_next_s   = {{CNT_W{1'b0}}, cycle_cnt} + {{(BW-1){1'b0}}, 1'b1};
  assign budget_s     = {{CNT_W{1'b0}}, instr_limit} * MULT_W;
  assign limit_hit_s  = cpu_en & retire & (instr_limit != {CNT_W{1'b0}})
                        & (instr_next_s == {1'b0, instr_limit});
  assign wd_hit_s     = cpu_en & (instr_limit != {CNT_W{1'b0}}) & (cyc_next_s == budget_s);
  assign stop_s       = limit_hit_s | wd_hit_s;
  assign wd_only_s    = wd_hit_s & ~limit_hit_s;

`ifdef RUN_CTRL_BREAK_EN
  logic brk_hit_r;

  // Breakpoints yield to both stop conditions.
  assign brk_take_s = cpu_en & break_valid & (pc == break_pc) & ~stop_s;
  assign brk_hold_s = brk_hit_r;
  assign brk_hit    = brk_hit_r;

  // Breakpoint flag: set on a taken breakpoint, cleared by a step edge or a new run.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_hit_r <= 1'b0;
    end else if (brk_take_s) begin
      brk_hit_r <= 1'b1;
    end else if (start_ok_s || step_rise_s) begin
      brk_hit_r <= 1'b0;
    end else begin
      brk_hit_r <= brk_hit_r;
    end
  end
`else
  assign brk_take_s = 1'b0;
  assign brk_hold_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = clk_select ? STEP_WAIT : RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (stop_s) begin
          state_nxt_s = DONE;
        end else if (brk_take_s || clk_select) begin
          state_nxt_s = STEP_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STEP_WAIT: begin
        // A pending breakpoint holds the core here even in free-run mode.
        if (step_rise_s) begin
          state_nxt_s = STEP_PULSE;
        end else if (!clk_select && !brk_hold_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = STEP_WAIT;
        end
      end
      STEP_PULSE: begin
        if (stop_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = STEP_WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    cpu_en  = 1'b0;
    running = 1'b0;
    done    = 1'b0;
    case (state_r)
      RUN: begin
        cpu_en  = 1'b1;
        running = 1'b1;
      end
      STEP_WAIT: begin
        running = 1'b1;
      end
      STEP_PULSE: begin
        cpu_en  = 1'b1;
        running = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        cpu_en  = 1'b0;
        running = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  // Step-edge history, counters and timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_step_q_r <= clk_step;
      cycle_cnt    <= {CNT_W{1'b0}};
      instr_cnt    <= {CNT_W{1'b0}};
      stall_cnt    <= {CNT_W{1'b0}};
      timeout      <= 1'b0;
    end else begin
      clk_step_q_r <= clk_step;
      if (start_ok_s) begin
        cycle_cnt <= {CNT_W{1'b0}};
        instr_cnt <= {CNT_W{1'b0}};
        stall_cnt <= {CNT_W{1'b0}};
        timeout   <= 1'b0;
      end else if (cpu_en) begin
        cycle_cnt <= cnt_inc(cycle_cnt);
        instr_cnt <= retire ? cnt_inc(instr_cnt) : instr_cnt;
        stall_cnt <= stall ? cnt_inc(stall_cnt) : stall_cnt;
        timeout   <= timeout | wd_only_s;
      end else begin
        cycle_cnt <= cycle_cnt;
        instr_cnt <= instr_cnt;
        stall_cnt <= stall_cnt;
        timeout   <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_run_control_unit.sv
// Directed self-checking bench for run_control_unit (default build, breakpoints off).
module tb_run_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_select = 1'b0;
  logic        clk_step = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr_limit = 32'd0;
  logic        retire = 1'b0;
  logic        stall = 1'b0;
  logic        cpu_en, running, done, timeout;
  logic [31:0] cycle_cnt, instr_cnt, stall_cnt;
`ifdef RUN_CTRL_BREAK_EN
  logic        break_valid = 1'b0;
  logic [31:0] break_pc = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        brk_hit;
`endif

  int checks = 0;
  int errors = 0;

  run_control_unit dut (
    .clk(clk), .rst(rst), .clk_select(clk_select), .clk_step(clk_step), .start(start),
    .instr_limit(instr_limit), .retire(retire), .stall(stall),
`ifdef RUN_CTRL_BREAK_EN
    .break_valid(break_valid), .break_pc(break_pc), .pc(pc), .brk_hit(brk_hit),
`endif
    .cpu_en(cpu_en), .running(running), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b expected 0", cpu_en); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", cycle_cnt, instr_cnt, stall_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  // Retire on every 6th enabled cycle, stall on the other five.
  task automatic test_limit_stop();
    int en = 0;
    int n = 0;
    logic was_en;
    clk_select = 1'b0;
    instr_limit = 32'd10;
    pulse_start();
    while (done !== 1'b1 && n < 200) begin
      if (cpu_en === 1'b1) begin
        retire = (((en + 1) % 6) == 0);
        stall = ~retire;
      end else begin
        retire = 1'b0;
        stall = 1'b0;
      end
      was_en = cpu_en;
      tick();
      if (was_en === 1'b1) en++;
      n++;
    end
    retire = 1'b0;
    stall = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL limit_done: got %b expected 1 within 200 cycles", done); end
    checks++; if (en != 60) begin errors++; $display("FAIL limit_enabled_cycles: got %0d expected 60", en); end
    checks++; if (cycle_cnt !== 32'd60) begin errors++; $display("FAIL limit_cycle_cnt: got %0d expected 60", cycle_cnt); end
    checks++; if (instr_cnt !== 32'd10) begin errors++; $display("FAIL limit_instr_cnt: got %0d expected 10", instr_cnt); end
    checks++; if (stall_cnt !== 32'd50) begin errors++; $display("FAIL limit_stall_cnt: got %0d expected 50", stall_cnt); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL limit_timeout: got %b expected 0", timeout); end
    checks++; if (cpu_en !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL limit_halted: got cpu_en=%b running=%b expected 0/0", cpu_en, running);
    end
    retire = 1'b1;
    stall = 1'b1;
    tick();
    tick();
    checks++; if (cycle_cnt !== 32'd60 || instr_cnt !== 32'd10 || stall_cnt !== 32'd50 || done !== 1'b1) begin
      errors++; $display("FAIL limit_hold: got %0d/%0d/%0d done=%b expected 60/10/50 done=1", cycle_cnt, instr_cnt, stall_cnt, done);
    end
    retire = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_watchdog();
    int n = 0;
    instr_limit = 32'd10;
    clk_select = 1'b0;
    pulse_start();
    checks++; if (cycle_cnt !== 32'd0 || timeout !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL wd_restart: got cycle=%0d timeout=%b running=%b expected 0/0/1", cycle_cnt, timeout, running);
    end
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wd_done: got %b expected 1 within 200 cycles", done); end
    checks++; if (cycle_cnt !== 32'd60) begin errors++; $display("FAIL wd_cycle_cnt: got %0d expected 60", cycle_cnt); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout: got %b expected 1", timeout); end
    checks++; if (instr_cnt !== 32'd0) begin errors++; $display("FAIL wd_instr_cnt: got %0d expected 0", instr_cnt); end
  endtask

  task automatic test_limit_one();
    int n = 0;
    instr_limit = 32'd1;
    clk_select = 1'b0;
    pulse_start();
    retire = 1'b1;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    retire = 1'b0;
    checks++; if (cycle_cnt !== 32'd1 || instr_cnt !== 32'd1) begin
      errors++; $display("FAIL limit1_counts: got %0d/%0d expected 1/1", cycle_cnt, instr_cnt);
    end
    checks++; if (done !== 1'b1 || timeout !== 1'b0) begin
      errors++; $display("FAIL limit1_flags: got done=%b timeout=%b expected 1/0", done, timeout);
    end
  endtask

  task automatic test_single_step();
    int pulses = 0;
    int run = 0;
    int max_run = 0;
    int en = 0;
    instr_limit = 32'd0;
    clk_select = 1'b1;
    pulse_start();
    checks++; if (running !== 1'b1 || cpu_en !== 1'b0) begin
      errors++; $display("FAIL step_wait_entry: got running=%b cpu_en=%b expected 1/0", running, cpu_en);
    end
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 10; c++) begin
        clk_step = (c < 5);
        tick();
        if (cpu_en === 1'b1) begin
          run++;
          if (run == 1) pulses++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
    end
    clk_step = 1'b0;
    checks++; if (pulses != 3) begin errors++; $display("FAIL step_pulses: got %0d expected 3", pulses); end
    checks++; if (max_run != 1) begin errors++; $display("FAIL step_pulse_width: got %0d expected 1", max_run); end
    checks++; if (cycle_cnt !== 32'd3) begin errors++; $display("FAIL step_cycle_cnt: got %0d expected 3", cycle_cnt); end
    // Button held across reset must not produce a step.
    clk_step = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (running !== 1'b0 || cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL step_rst_state: got running=%b cycle=%0d expected 0/0", running, cycle_cnt);
    end
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      if (c == 5) clk_step = 1'b0;
      tick();
      if (cpu_en === 1'b1) en++;
    end
    checks++; if (en != 0 || cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL step_held_through_reset: got en=%0d cycle=%0d expected 0/0", en, cycle_cnt);
    end
  endtask

  task automatic test_mode_switch();
    int n = 0;
    int en = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_limit = 32'd0;
    clk_select = 1'b0;
    pulse_start();
    while (cycle_cnt !== 32'd19 && n < 100) begin
      tick();
      n++;
    end
    checks++; if (cycle_cnt !== 32'd19) begin errors++; $display("FAIL mode_reach19: got %0d expected 19", cycle_cnt); end
    clk_select = 1'b1;
    tick();
    checks++; if (cycle_cnt !== 32'd20 || cpu_en !== 1'b0) begin
      errors++; $display("FAIL mode_stop: got cycle=%0d cpu_en=%b expected 20/0", cycle_cnt, cpu_en);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cpu_en === 1'b1) en++;
    end
    checks++; if (en != 0 || cycle_cnt !== 32'd20) begin
      errors++; $display("FAIL mode_paused: got en=%0d cycle=%0d expected 0/20", en, cycle_cnt);
    end
    clk_select = 1'b0;
    tick();
    checks++; if (cpu_en !== 1'b1 || cycle_cnt !== 32'd20) begin
      errors++; $display("FAIL mode_resume: got cpu_en=%b cycle=%0d expected 1/20", cpu_en, cycle_cnt);
    end
    repeat (5) tick();
    checks++; if (cycle_cnt !== 32'd25) begin errors++; $display("FAIL mode_count_on: got %0d expected 25", cycle_cnt); end
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    while (cycle_cnt !== 32'd30 && n < 100) begin
      tick();
      n++;
    end
    pulse_start();
    checks++; if (cycle_cnt !== 32'd31) begin errors++; $display("FAIL start_while_running: got %0d expected 31", cycle_cnt); end
    n = 0;
    while (cycle_cnt !== 32'd37 && n < 100) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (cpu_en !== 1'b0 || running !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got %b%b%b%b expected 0000", cpu_en, running, done, timeout);
    end
    checks++; if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      errors++; $display("FAIL midrst_counters: got %0d/%0d/%0d expected 0/0/0", cycle_cnt, instr_cnt, stall_cnt);
    end
    tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL midrst_idle: got running=%b expected 0", running); end
    pulse_start();
    checks++; if (cycle_cnt !== 32'd0 || cpu_en !== 1'b1) begin
      errors++; $display("FAIL midrst_restart: got cycle=%0d cpu_en=%b expected 0/1", cycle_cnt, cpu_en);
    end
    tick();
    checks++; if (cycle_cnt !== 32'd1) begin errors++; $display("FAIL midrst_count: got %0d expected 1", cycle_cnt); end
  endtask

  initial begin
    test_reset();
    test_limit_stop();
    test_watchdog();
    test_limit_one();
    test_single_step();
    test_mode_switch();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
